riscv_sim_monitor: RTL and testbench

RISCV_SIM_MONITOR -- requirements
Module: riscv_sim_monitor

---
 rtl/riscv_sim_monitor.sv | 187 ++++++++++++++++++
 tb/tb_riscv_sim_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_sim_monitor.sv
// rtl/riscv_sim_monitor.sv - end-of-program, tohost and address-watch monitor for a RISC-V core under simulation
//
// Purpose: watches the retire and data-memory streams of a core running a test
// program, decides pass/fail (END_PC retire, tohost store, cycle timeout), keeps
// cycle/retire counters, captures the last store and flags watched addresses.
//
// Ports:
//   clk, reset_n                  clock (rising edge), asynchronous active-low reset
//   retire_valid, retire_pc       one instruction retires this cycle, with its PC
//   dm_we, dm_re, dm_addr,
//   dm_wdata                      data memory access this cycle
//   watch_base, watch_mask        NUM_WATCH packed 32-bit windows, window i = [32i+31:32i]
//   state                         IDLE=0, RUN=1, DRAIN=2, DONE=3, FAIL=4
//   done, pass, timeout,
//   fail_code                     verdict outputs
//   cycle_count, retire_count     saturating counters, live in RUN/DRAIN
//   watch_hit, watch_seen         per-window one-cycle pulse / sticky flag
//   last_st_addr, last_st_data    most recent store seen while not terminal
module riscv_sim_monitor #(
  parameter logic [31:0] END_PC         = 32'h0000009c,
  parameter logic [31:0] TOHOST_ADDR    = 32'h00100000,
  parameter int          DRAIN_CYCLES   = 4,
  parameter int          TIMEOUT_CYCLES = 400000000,
  parameter int          NUM_WATCH      = 4,
  parameter int          CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     retire_valid,
  input  logic [31:0]              retire_pc,
  input  logic                     dm_we,
  input  logic                     dm_re,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_wdata,
  input  logic [NUM_WATCH*32-1:0]  watch_base,
  input  logic [NUM_WATCH*32-1:0]  watch_mask,
  output logic [2:0]               state,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [30:0]              fail_code,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         retire_count,
  output logic [NUM_WATCH-1:0]     watch_hit,
  output logic [NUM_WATCH-1:0]     watch_seen,
  output logic [31:0]              last_st_addr,
  output logic [31:0]              last_st_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  localparam logic [31:0]      DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t               r_state;
  logic [31:0]          r_drain_cnt;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_timeout;
  logic [30:0]          r_fail_code;
  logic [CNT_W-1:0]     r_cycle;
  logic [CNT_W-1:0]     r_retire;
  logic [NUM_WATCH-1:0] r_watch_hit;
  logic [NUM_WATCH-1:0] r_watch_seen;
  logic [31:0]          r_last_addr;
  logic [31:0]          r_last_data;

  logic                 w_live;
  logic                 w_tohost;
  logic                 w_timeout;
  logic                 w_end_pc;
  logic [CNT_W-1:0]     w_cycle_inc;
  logic [CNT_W-1:0]     w_retire_inc;
  logic [NUM_WATCH-1:0] w_watch_match;

  // Non-terminal covers IDLE too: watches and store capture work before RUN.
  assign w_live       = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_tohost     = dm_we && (dm_addr == TOHOST_ADDR);
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cycle == TO_LAST);
  assign w_end_pc     = retire_valid && (retire_pc == END_PC);
  assign w_cycle_inc  = (r_cycle  == '1) ? r_cycle  : r_cycle  + CNT_ONE;
  assign w_retire_inc = (r_retire == '1) ? r_retire : r_retire + CNT_ONE;

  always_comb begin
    w_watch_match = '0;
    for (int i = 0; i < NUM_WATCH; i++) begin
      w_watch_match[i] = (dm_we || dm_re) &&
        ((dm_addr & watch_mask[32*i +: 32]) == (watch_base[32*i +: 32] & watch_mask[32*i +: 32]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_drain_cnt  <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_fail_code  <= '0;
      r_cycle      <= '0;
      r_retire     <= '0;
      r_watch_hit  <= '0;
      r_watch_seen <= '0;
      r_last_addr  <= '0;
      r_last_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (retire_valid) begin
            r_state  <= S_RUN;
            r_retire <= CNT_ONE;
          end
        end
        S_RUN, S_DRAIN: begin
          r_cycle <= w_cycle_inc;
          if (retire_valid) r_retire <= w_retire_inc;
          // Verdict priority: tohost store, then timeout, then END_PC / drain expiry.
          if (w_tohost) begin
            r_done <= 1'b1;
            if (dm_wdata == 32'd1) begin
              r_state <= S_DONE;
              r_pass  <= 1'b1;
            end else begin
              r_state     <= S_FAIL;
              r_fail_code <= dm_wdata[31:1];
            end
          end else if (w_timeout) begin
            r_state     <= S_FAIL;
            r_done      <= 1'b1;
            r_timeout   <= 1'b1;
            r_fail_code <= '0;
          end else if (r_state == S_RUN) begin
            if (w_end_pc) begin
              if (DRAIN_CYCLES == 0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_pass  <= 1'b1;
              end else begin
                r_state     <= S_DRAIN;
                r_drain_cnt <= DRAIN_LOAD;
              end
            end
          end else if (r_drain_cnt == 32'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 32'd1;
          end
        end
        default: ;
      endcase

      if (w_live) begin
        r_watch_hit  <= w_watch_match;
        r_watch_seen <= r_watch_seen | w_watch_match;
        if (dm_we) begin
          r_last_addr <= dm_addr;
          r_last_data <= dm_wdata;
        end
      end else begin
        // A pulse from the final live cycle must not stick high forever.
        r_watch_hit <= '0;
      end
    end
  end

  assign state        = r_state;
  assign done         = r_done;
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign fail_code    = r_fail_code;
  assign cycle_count  = r_cycle;
  assign retire_count = r_retire;
  assign watch_hit    = r_watch_hit;
  assign watch_seen   = r_watch_seen;
  assign last_st_addr = r_last_addr;
  assign last_st_data = r_last_data;

endmodule

// File: tb/tb_riscv_sim_monitor.sv
// tb/tb_riscv_sim_monitor.sv - directed self-checking bench for riscv_sim_monitor
module tb_riscv_sim_monitor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         retire_valid;
  logic [31:0]  retire_pc;
  logic         dm_we;
  logic         dm_re;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic [127:0] watch_base;
  logic [127:0] watch_mask;

  // a: defaults, b: TIMEOUT_CYCLES=20, c: DRAIN_CYCLES=0, d: CNT_W=4 with no timeout
  logic [2:0]  a_state, b_state, c_state, d_state;
  logic        a_done, b_done, c_done, d_done;
  logic        a_pass, b_pass, c_pass, d_pass;
  logic        a_to, b_to, c_to, d_to;
  logic [30:0] a_fc, b_fc, c_fc, d_fc;
  logic [31:0] a_cyc, b_cyc, c_cyc;
  logic [31:0] a_ret, b_ret, c_ret;
  logic [3:0]  d_cyc, d_ret;
  logic [3:0]  a_hit, b_hit, c_hit, d_hit;
  logic [3:0]  a_seen, b_seen, c_seen, d_seen;
  logic [31:0] a_lsa, b_lsa, c_lsa, d_lsa;
  logic [31:0] a_lsd, b_lsd, c_lsd, d_lsd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_sim_monitor u_a (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .watch_base(watch_base), .watch_mask(watch_mask),
    .state(a_state), .done(a_done), .pass(a_pass), .timeout(a_to), .fail_code(a_fc),
    .cycle_count(a_cyc), .retire_count(a_ret), .watch_hit(a_hit), .watch_seen(a_seen),
    .last_st_addr(a_lsa), .last_st_data(a_lsd));

  riscv_sim_monitor #(.TIMEOUT_CYCLES(20)) u_b (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .watch_base(watch_base), .watch_mask(watch_mask),
    .state(b_state), .done(b_done), .pass(b_pass), .timeout(b_to), .fail_code(b_fc),
    .cycle_count(b_cyc), .retire_count(b_ret), .watch_hit(b_hit), .watch_seen(b_seen),
    .last_st_addr(b_lsa), .last_st_data(b_lsd));

  riscv_sim_monitor #(.DRAIN_CYCLES(0)) u_c (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .watch_base(watch_base), .watch_mask(watch_mask),
    .state(c_state), .done(c_done), .pass(c_pass), .timeout(c_to), .fail_code(c_fc),
    .cycle_count(c_cyc), .retire_count(c_ret), .watch_hit(c_hit), .watch_seen(c_seen),
    .last_st_addr(c_lsa), .last_st_data(c_lsd));

  riscv_sim_monitor #(.TIMEOUT_CYCLES(0), .CNT_W(4)) u_d (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .watch_base(watch_base), .watch_mask(watch_mask),
    .state(d_state), .done(d_done), .pass(d_pass), .timeout(d_to), .fail_code(d_fc),
    .cycle_count(d_cyc), .retire_count(d_ret), .watch_hit(d_hit), .watch_seen(d_seen),
    .last_st_addr(d_lsa), .last_st_data(d_lsd));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    retire_valid = 1'b0;
    retire_pc    = '0;
    dm_we        = 1'b0;
    dm_re        = 1'b0;
    dm_addr      = '0;
    dm_wdata     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic retire(input logic [31:0] pc);
    retire_valid = 1'b1;
    retire_pc    = pc;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    dm_we    = 1'b1;
    dm_addr  = addr;
    dm_wdata = data;
    tick();
    dm_we    = 1'b0;
  endtask

  task automatic run_to_cycle19();
    retire(32'h0);
    for (int i = 0; i < 40 && b_cyc != 32'd19; i++) tick();
    check_eq("b_reach_cyc19", b_cyc, 19);
  endtask

  initial begin
    watch_base = {{3{32'hFFFFFFF0}}, 32'h00100000};
    watch_mask = {{3{32'hFFFFFFFF}}, 32'hFFF00000};
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    check_eq("rst_state",   a_state, 0);
    check_eq("rst_done",    a_done, 0);
    check_eq("rst_pass",    a_pass, 0);
    check_eq("rst_timeout", a_to, 0);
    check_eq("rst_fc",      a_fc, 0);
    check_eq("rst_cycle",   a_cyc, 0);
    check_eq("rst_retire",  a_ret, 0);
    check_eq("rst_seen",    a_seen, 0);
    check_eq("rst_lsa",     a_lsa, 0);
    reset_n = 1'b1;
    tick();
    tick();
    check_eq("idle_state", a_state, 0);
    check_eq("idle_cycle", a_cyc, 0);

    // reset asserted in the middle of DRAIN
    for (int i = 0; i < 10; i++) retire(32'(i * 4));
    retire(32'h9c);
    check_eq("pre_drain_state", a_state, 2);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_state",  a_state, 0);
    check_eq("async_rst_cycle",  a_cyc, 0);
    check_eq("async_rst_retire", a_ret, 0);
    check_eq("async_rst_done",   a_done, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // full program: 10 retires, 3 gap cycles, END_PC, drain with store and extra retire
    retire(32'h0);
    check_eq("run_state",   a_state, 1);
    check_eq("run_retire1", a_ret, 1);
    check_eq("run_cycle0",  a_cyc, 0);
    for (int i = 1; i < 10; i++) retire(32'(i * 4));
    tick();
    tick();
    tick();
    retire(32'h9c);
    check_eq("end_state_drain", a_state, 2);
    check_eq("end_retire11",    a_ret, 11);
    check_eq("end_cycle13",     a_cyc, 13);
    check_eq("c_done_state",    c_state, 3);
    check_eq("c_done_pass",     c_pass, 1);
    store(32'h00002000, 32'h0000ABCD);
    check_eq("drain1_state", a_state, 2);
    check_eq("drain_lsa",    a_lsa, 32'h00002000);
    check_eq("drain_lsd",    a_lsd, 32'h0000ABCD);
    check_eq("c_lsa_frozen", c_lsa, 0);
    check_eq("c_lsd_frozen", c_lsd, 0);
    retire(32'ha0);
    check_eq("drain2_state", a_state, 2);
    tick();
    check_eq("drain3_state", a_state, 2);
    tick();
    check_eq("done_state",  a_state, 3);
    check_eq("done_done",   a_done, 1);
    check_eq("done_pass",   a_pass, 1);
    check_eq("done_retire", a_ret, 12);
    check_eq("done_cycle",  a_cyc, 17);
    check_eq("d_cycle_sat", d_cyc, 15);
    check_eq("d_retire",    d_ret, 12);
    retire(32'h0);
    check_eq("frozen_retire", a_ret, 12);
    check_eq("frozen_cycle",  a_cyc, 17);

    // tohost failure code
    do_reset();
    retire(32'h0);
    store(32'h00100000, 32'h00000007);
    check_eq("th_state",   a_state, 4);
    check_eq("th_pass",    a_pass, 0);
    check_eq("th_done",    a_done, 1);
    check_eq("th_fc",      a_fc, 3);
    check_eq("th_timeout", a_to, 0);

    // timeout on instance b
    do_reset();
    run_to_cycle19();
    tick();
    check_eq("to_state",   b_state, 4);
    check_eq("to_timeout", b_to, 1);
    check_eq("to_fc",      b_fc, 0);
    check_eq("to_pass",    b_pass, 0);
    check_eq("to_a_run",   a_state, 1);

    // tohost pass store coinciding with timeout
    do_reset();
    run_to_cycle19();
    store(32'h00100000, 32'h00000001);
    check_eq("prio_state",   b_state, 3);
    check_eq("prio_timeout", b_to, 0);
    check_eq("prio_pass",    b_pass, 1);

    // watch window 0
    do_reset();
    retire(32'h0);
    dm_re   = 1'b1;
    dm_addr = 32'h00100010;
    tick();
    check_eq("w_hit_pulse", a_hit, 4'b0001);
    check_eq("w_seen_set",  a_seen, 4'b0001);
    dm_re = 1'b0;
    tick();
    check_eq("w_hit_clear", a_hit, 4'b0000);
    check_eq("w_seen_hold", a_seen, 4'b0001);
    dm_re   = 1'b1;
    dm_addr = 32'h00200000;
    tick();
    check_eq("w_miss_hit",  a_hit, 4'b0000);
    check_eq("w_miss_seen", a_seen, 4'b0001);
    dm_re = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
